// File: rtl/kiosk_sell_arbiter_pkg.sv
// Shared definitions for the kiosk sell arbiter: field widths, FSM encoding,
// the per-transaction route record and the saturating payment adder.
package kiosk_sell_arbiter_pkg;

   localparam int STN_W  = 3;
   localparam int COIN_W = 6;
   localparam int AMT_W  = 7;

   localparam logic [AMT_W-1:0] AMT_MAX = 7'd127;

   // FSM encoding, kept as plain constants so older tools can share it
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_GRANT = 3'd1;
   localparam logic [2:0] ST_START = 3'd2;
   localparam logic [2:0] ST_PAY   = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;
   localparam logic [2:0] ST_ABORT = 3'd5;

   // Route captured from the owning kiosk when the engine is granted
   typedef struct packed {
      logic [STN_W-1:0] origin;
      logic [STN_W-1:0] dest;
      logic [STN_W-1:0] count;
   } route_t;

   // Add a coin to the running total, clamping at the largest amount
   function automatic logic [AMT_W-1:0] amt_add_sat(input logic [AMT_W-1:0] acc,
                                                   input logic [COIN_W-1:0] coin);
      logic [AMT_W:0] sum;
      sum = {1'b0, acc} + {2'b00, coin};
      amt_add_sat = sum[AMT_W] ? AMT_MAX : sum[AMT_W-1:0];
   endfunction

endpackage

// File: rtl/kiosk_sell_arbiter_if.sv
// Bundle of kiosk-panel and sell-engine signals around the arbiter.
// slave  : the arbiter itself.
// master : the environment (kiosk panels plus sell engine).
interface kiosk_sell_arbiter_if
   import kiosk_sell_arbiter_pkg::*;
#(
   parameter int N_KIOSK = 4
);

   // kiosk side
   logic [N_KIOSK-1:0]        kiosk_req;
   logic [STN_W*N_KIOSK-1:0]  kiosk_origin;
   logic [STN_W*N_KIOSK-1:0]  kiosk_dest;
   logic [STN_W*N_KIOSK-1:0]  kiosk_count;
   logic [N_KIOSK-1:0]        kiosk_coin_vld;
   logic [COIN_W*N_KIOSK-1:0] kiosk_coin;
   logic [N_KIOSK-1:0]        kiosk_grant;
   logic [N_KIOSK-1:0]        kiosk_done;
   logic [N_KIOSK-1:0]        kiosk_abort;
   logic [AMT_W-1:0]          change_amt;

   // engine side
   logic                      eng_start;
   logic [STN_W-1:0]          eng_origin;
   logic [STN_W-1:0]          eng_dest;
   logic [STN_W-1:0]          eng_count;
   logic                      eng_coin_vld;
   logic [COIN_W-1:0]         eng_coin;
   logic                      eng_cancel;
   logic                      eng_done;
   logic [AMT_W-1:0]          eng_change;

   modport slave (
      input  kiosk_req, kiosk_origin, kiosk_dest, kiosk_count,
      input  kiosk_coin_vld, kiosk_coin,
      output kiosk_grant, kiosk_done, kiosk_abort, change_amt,
      output eng_start, eng_origin, eng_dest, eng_count,
      output eng_coin_vld, eng_coin, eng_cancel,
      input  eng_done, eng_change
   );

   modport master (
      output kiosk_req, kiosk_origin, kiosk_dest, kiosk_count,
      output kiosk_coin_vld, kiosk_coin,
      input  kiosk_grant, kiosk_done, kiosk_abort, change_amt,
      input  eng_start, eng_origin, eng_dest, eng_count,
      input  eng_coin_vld, eng_coin, eng_cancel,
      output eng_done, eng_change
   );

endinterface

// File: rtl/kiosk_sell_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker. Returns the index of the first
// set request bit at or after ptr, wrapping modulo N.
module kiosk_sell_arbiter_rr_pick #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] idx,
   output logic          valid
);

   logic [IW-1:0] cand [N];
   logic [N-1:0]  hit;

   // cand[k] is the kiosk index k places after the pointer, wrapped into range
   genvar gi;
   for (gi = 0; gi < N; gi++) begin : g_cand
      logic [IW:0] sum;
      assign sum       = {1'b0, ptr} + (IW+1)'(gi);
      assign cand[gi]  = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
      assign hit[gi]   = req[cand[gi]];
   end

   // Smallest offset from the pointer wins; scan downward so it is written last
   always_comb begin
      idx   = '0;
      valid = |hit;
      for (int k = N - 1; k >= 0; k--) begin
         if (hit[k]) begin
            idx = cand[k];
         end
      end
   end

endmodule

// File: rtl/kiosk_sell_arbiter.sv
// Shares one fare/payment engine among N_KIOSK kiosk panels. A round-robin
// pick locks the engine to one kiosk for a whole sale, forwards its route and
// coins, and returns done/abort with change or refund to that kiosk.
module kiosk_sell_arbiter
   import kiosk_sell_arbiter_pkg::*;
#(
   parameter int N_KIOSK = 4,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                reset,
   kiosk_sell_arbiter_if.slave bus
);

   localparam int IW = $clog2(N_KIOSK);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TIMEOUT_V = TW'(TIMEOUT);

   logic [2:0]         state_q,  state_d;
   logic [IW-1:0]      owner_q,  owner_d;
   logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
   route_t             route_q,  route_d;
   logic [N_KIOSK-1:0] grant_q,  grant_d;
   logic [AMT_W-1:0]   change_q, change_d;
   logic [AMT_W-1:0]   paid_q,   paid_d;
   logic [TW-1:0]      timer_q,  timer_d;

   logic [STN_W-1:0]   origin_arr [N_KIOSK];
   logic [STN_W-1:0]   dest_arr   [N_KIOSK];
   logic [STN_W-1:0]   count_arr  [N_KIOSK];
   logic [COIN_W-1:0]  coin_arr   [N_KIOSK];

   logic [IW-1:0]      pick_idx;
   logic               pick_vld;
   logic               owner_req;
   logic               coin_in_pay;
   logic [COIN_W-1:0]  owner_coin;
   logic [AMT_W-1:0]   paid_add;

   // Unpack the flat per-kiosk buses into indexable arrays
   genvar gi;
   for (gi = 0; gi < N_KIOSK; gi++) begin : g_unpack
      assign origin_arr[gi] = bus.kiosk_origin[gi*STN_W +: STN_W];
      assign dest_arr[gi]   = bus.kiosk_dest[gi*STN_W +: STN_W];
      assign count_arr[gi]  = bus.kiosk_count[gi*STN_W +: STN_W];
      assign coin_arr[gi]   = bus.kiosk_coin[gi*COIN_W +: COIN_W];
   end

   kiosk_sell_arbiter_rr_pick #(
      .N  (N_KIOSK),
      .IW (IW)
   ) u_rr_pick (
      .req   (bus.kiosk_req),
      .ptr   (rr_ptr_q),
      .idx   (pick_idx),
      .valid (pick_vld)
   );

   // Only the owner's coin strobe reaches the engine, and only while paying;
   // strobes from other kiosks are simply never selected.
   assign owner_req   = bus.kiosk_req[owner_q];
   assign owner_coin  = coin_arr[owner_q];
   assign coin_in_pay = (state_q == ST_PAY) && bus.kiosk_coin_vld[owner_q];
   assign paid_add    = coin_in_pay ? amt_add_sat(paid_q, owner_coin) : paid_q;

   assign bus.eng_coin_vld = coin_in_pay;
   assign bus.eng_coin     = coin_in_pay ? owner_coin : '0;
   assign bus.eng_start    = (state_q == ST_START);
   assign bus.eng_cancel   = (state_q == ST_ABORT);
   assign bus.eng_origin   = route_q.origin;
   assign bus.eng_dest     = route_q.dest;
   assign bus.eng_count    = route_q.count;
   assign bus.kiosk_grant  = grant_q;
   assign bus.kiosk_done   = (state_q == ST_DONE)  ? grant_q : '0;
   assign bus.kiosk_abort  = (state_q == ST_ABORT) ? grant_q : '0;
   assign bus.change_amt   = change_q;

   // Transaction FSM with owner/route capture, payment accounting and timeout
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      route_d  = route_q;
      grant_d  = grant_q;
      change_d = change_q;
      paid_d   = paid_q;
      timer_d  = timer_q;

      case (state_q)
         ST_IDLE: begin
            if (pick_vld) begin
               owner_d           = pick_idx;
               grant_d           = '0;
               grant_d[pick_idx] = 1'b1;
               route_d.origin    = origin_arr[pick_idx];
               route_d.dest      = dest_arr[pick_idx];
               // a ticket count of zero still sells one ticket
               route_d.count     = (count_arr[pick_idx] == '0) ? STN_W'(1)
                                                               : count_arr[pick_idx];
               state_d           = ST_GRANT;
            end
         end

         ST_GRANT: state_d = ST_START;

         ST_START: state_d = ST_PAY;

         ST_PAY: begin
            paid_d  = paid_add;
            timer_d = coin_in_pay ? '0 : timer_q + 1'b1;
            // completion outranks withdrawal, which outranks timeout
            if (bus.eng_done) begin
               change_d = bus.eng_change;
               state_d  = ST_DONE;
            end else if (!owner_req) begin
               change_d = paid_add;
               state_d  = ST_ABORT;
            end else if (timer_q == TIMEOUT_V) begin
               change_d = paid_add;
               state_d  = ST_ABORT;
            end
         end

         ST_DONE, ST_ABORT: begin
            // the just-served kiosk goes to the back of the queue
            rr_ptr_d = (owner_q == IW'(N_KIOSK - 1)) ? '0 : owner_q + 1'b1;
            grant_d  = '0;
            paid_d   = '0;
            timer_d  = '0;
            state_d  = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // State registers; reset abandons any sale without a done/abort pulse
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         owner_q  <= '0;
         rr_ptr_q <= '0;
         route_q  <= '0;
         grant_q  <= '0;
         change_q <= '0;
         paid_q   <= '0;
         timer_q  <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
         route_q  <= route_d;
         grant_q  <= grant_d;
         change_q <= change_d;
         paid_q   <= paid_d;
         timer_q  <= timer_d;
      end
   end

endmodule
